// File: rtl/timer_ctrl_pkg.sv
// Shared field codes, edit-FSM state encoding and default timing constants
// for the edit controller and the SS_T/MM_T/HH_T timer counters.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEL_SS = 2'd1,
    SEL_MM = 2'd2,
    SEL_HH = 2'd3
  } state_t;

  localparam logic [3:0] NONE_T = 4'd0;
  localparam logic [3:0] SS_T   = 4'd8;
  localparam logic [3:0] MM_T   = 4'd9;
  localparam logic [3:0] HH_T   = 4'd10;

  localparam int DEF_REPEAT_DLY = 50_000_000;
  localparam int DEF_REPEAT_PER = 10_000_000;
  localparam int DEF_TIMEOUT    = 500_000_000;

  function automatic logic [3:0] field_code(state_t s);
    logic [3:0] c;
    c = NONE_T;
    unique case (s)
      SEL_SS: c = SS_T;
      SEL_MM: c = MM_T;
      SEL_HH: c = HH_T;
      default: c = NONE_T;
    endcase
    return c;
  endfunction

  // Toward hours: SS -> MM -> HH -> SS
  function automatic state_t field_right(state_t s);
    state_t n;
    n = s;
    unique case (s)
      SEL_SS: n = SEL_MM;
      SEL_MM: n = SEL_HH;
      SEL_HH: n = SEL_SS;
      default: n = s;
    endcase
    return n;
  endfunction

  // Toward seconds: SS -> HH -> MM -> SS
  function automatic state_t field_left(state_t s);
    state_t n;
    n = s;
    unique case (s)
      SEL_SS: n = SEL_HH;
      SEL_MM: n = SEL_SS;
      SEL_HH: n = SEL_MM;
      default: n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Rising-edge detect plus hold/auto-repeat counter for one step button.
// Ports: clk, reset (sync, active low), btn level, block (other button
// held), enable (selected field stable this cycle), pulse (registered).
module btn_repeat
  import timer_ctrl_pkg::*;
#(
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic block,
  input  logic enable,
  output logic pulse
);

  localparam int MAXV =
    (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CW = $clog2(MAXV + 1);

  localparam logic [CW-1:0] C_DLY = CW'(REPEAT_DLY);
  localparam logic [CW-1:0] C_PER = CW'(REPEAT_PER);
  localparam logic [CW-1:0] C_MAX = CW'(MAXV);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic          prev;
  logic          rep;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          armed;
  logic          hit;
  logic          run;
  logic          fire;

  assign rise  = btn & ~prev;
  // A non-zero count means a press is being tracked since its edge.
  assign armed = cnt != '0;
  assign hit   = armed & btn &
                 (rep ? (cnt == C_PER) : (cnt == C_DLY));
  assign run   = enable & ~block & btn;
  assign fire  = run & (rise | hit);

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Load the live level so a held button gives no edge later.
      prev  <= btn;
      cnt   <= '0;
      rep   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= btn;
      pulse <= fire;
      if (!run) begin
        cnt <= '0;
        rep <= 1'b0;
      end else if (rise) begin
        cnt <= C_ONE;
        rep <= 1'b0;
      end else if (hit) begin
        cnt <= C_ONE;
        rep <= 1'b1;
      end else if (armed && cnt != C_MAX) begin
        cnt <= cnt + C_ONE;
      end
    end
  end

endmodule

// File: rtl/ctrl_edit_timer.sv
// Edit-mode controller: selects the timer field being edited and issues
// single-cycle up/down step pulses with auto-repeat and idle timeout.
// Ports: clk, reset (sync, active low), btn_edit/left/right/up/down,
// en_count (field code), enUP/enDOWN (step pulses), edit_active.
module ctrl_edit_timer
  import timer_ctrl_pkg::*;
#(
  parameter int REPEAT_DLY = DEF_REPEAT_DLY,
  parameter int REPEAT_PER = DEF_REPEAT_PER,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_edit,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       edit_active
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  state_t          state;
  state_t          state_next;
  logic [3:0]      en_count_next;
  logic            edit_q;
  logic            left_q;
  logic            right_q;
  logic            edit_e;
  logic            left_e;
  logic            right_e;
  logic [TW-1:0]   tcnt;
  logic            any_btn;
  logic            sel;
  logic            timeout;
  logic            hold_ok;

  assign edit_e  = btn_edit & ~edit_q;
  assign left_e  = btn_left & ~left_q;
  assign right_e = btn_right & ~right_q;

  assign any_btn = |{btn_edit, btn_left, btn_right,
                     btn_up, btn_down};
  assign sel     = state != IDLE;
  assign timeout = sel && !any_btn && (tcnt == T_LAST);
  // Steps are only allowed while the selected field holds steady.
  assign hold_ok = sel && (state_next == state);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      en_count <= NONE_T;
    end else begin
      state    <= state_next;
      en_count <= en_count_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!sel) begin
      if (edit_e) state_next = SEL_MM;
    end else if (edit_e || timeout) begin
      state_next = IDLE;
    end else if (right_e && !left_e) begin
      state_next = field_right(state);
    end else if (left_e && !right_e) begin
      state_next = field_left(state);
    end
  end

  always_comb begin
    en_count_next = field_code(state_next);
    edit_active   = sel;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      edit_q  <= btn_edit;
      left_q  <= btn_left;
      right_q <= btn_right;
      tcnt    <= '0;
    end else begin
      edit_q  <= btn_edit;
      left_q  <= btn_left;
      right_q <= btn_right;
      if (!sel || any_btn) begin
        tcnt <= '0;
      end else if (tcnt != T_LAST) begin
        tcnt <= tcnt + T_ONE;
      end
    end
  end

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_up (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_up),
    .block  (btn_down),
    .enable (hold_ok),
    .pulse  (enUP)
  );

  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_down (
    .clk    (clk),
    .reset  (reset),
    .btn    (btn_down),
    .block  (btn_up),
    .enable (hold_ok),
    .pulse  (enDOWN)
  );

endmodule

// File: tb/tb_ctrl_edit_timer.sv
// Self-checking bench for ctrl_edit_timer: directed scenarios followed
// by random button activity, compared against a behavioural model.
module tb_ctrl_edit_timer;

  localparam int DLY = 5;
  localparam int PER = 3;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_edit = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [3:0] en_count;
  logic       enUP;
  logic       enDOWN;
  logic       edit_active;

  int nchk = 0;
  int nfail = 0;
  int seen_up = 0;
  int seen_dn = 0;

  // Model: field 0 = none, 1 = seconds, 2 = minutes, 3 = hours
  int m_f = 0;
  int up_age = 0;
  int dn_age = 0;
  int quiet = 0;
  bit up_arm = 0;
  bit dn_arm = 0;
  bit p_e = 0, p_l = 0, p_r = 0, p_u = 0, p_d = 0;
  bit x_up = 0, x_dn = 0;

  always #5 clk = ~clk;

  ctrl_edit_timer #(
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER),
    .TIMEOUT    (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_edit    (btn_edit),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .en_count    (en_count),
    .enUP        (enUP),
    .enDOWN      (enDOWN),
    .edit_active (edit_active)
  );

  function automatic int code(int f);
    case (f)
      1: return 8;
      2: return 9;
      3: return 10;
      default: return 0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  // Pulse on the press, then at DLY, DLY+PER, ... cycles after it.
  task automatic hold(input bit lvl, input bit rise,
                      input bit other, input bit stable,
                      inout bit arm, inout int age,
                      output bit req);
    req = 0;
    if (!stable || other || !lvl) begin
      arm = 0;
    end else if (rise) begin
      arm = 1;
      age = 0;
      req = 1;
    end else if (arm) begin
      age++;
      req = (age >= DLY) && ((age - DLY) % PER == 0);
    end
  endtask

  task automatic model_step();
    bit ee, le, re, ue, de, sel, anyb, stable;
    int nf;
    if (!reset) begin
      m_f = 0;
      up_arm = 0;
      dn_arm = 0;
      quiet = 0;
      x_up = 0;
      x_dn = 0;
    end else begin
      ee = btn_edit && !p_e;
      le = btn_left && !p_l;
      re = btn_right && !p_r;
      ue = btn_up && !p_u;
      de = btn_down && !p_d;
      sel = m_f != 0;
      anyb = btn_edit || btn_left || btn_right ||
             btn_up || btn_down;
      nf = m_f;
      if (!sel) begin
        if (ee) nf = 2;
      end else if (ee) begin
        nf = 0;
      end else if (!anyb && quiet == TO - 1) begin
        nf = 0;
      end else if (re && !le) begin
        nf = m_f % 3 + 1;
      end else if (le && !re) begin
        nf = (m_f + 1) % 3 + 1;
      end
      stable = sel && (nf == m_f);
      hold(btn_up, ue, btn_down, stable,
           up_arm, up_age, x_up);
      hold(btn_down, de, btn_up, stable,
           dn_arm, dn_age, x_dn);
      quiet = (sel && !anyb) ? quiet + 1 : 0;
      m_f = nf;
    end
    p_e = btn_edit;
    p_l = btn_left;
    p_r = btn_right;
    p_u = btn_up;
    p_d = btn_down;
  endtask

  task automatic cyc(input bit e, input bit l, input bit r,
                     input bit u, input bit d,
                     input bit rn = 1'b1);
    btn_edit = e;
    btn_left = l;
    btn_right = r;
    btn_up = u;
    btn_down = d;
    reset = rn;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("en_count", en_count, code(m_f));
    chk("edit_active", edit_active, m_f != 0);
    chk("enUP", enUP, x_up);
    chk("enDOWN", enDOWN, x_dn);
    if (enUP) seen_up++;
    if (enDOWN) seen_dn++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int b;
    bit lv[5];
    @(negedge clk);

    // Scenario 1: edit toggling
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("reset_en_count", en_count, 0);
    cyc(1, 0, 0, 0, 0);
    chk("s1_enter", en_count, 9);
    chk("s1_active", edit_active, 1);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    chk("s1_exit", en_count, 0);
    idle(2);

    // Scenario 2: field selection
    cyc(1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0, 0);
    chk("s2_r1", en_count, 10);
    idle(1);
    cyc(0, 0, 1, 0, 0);
    chk("s2_r2", en_count, 8);
    idle(1);
    cyc(0, 0, 1, 0, 0);
    chk("s2_r3", en_count, 9);
    idle(1);
    cyc(0, 1, 0, 0, 0);
    chk("s2_l1", en_count, 8);
    idle(1);
    cyc(0, 1, 1, 0, 0);
    chk("s2_both", en_count, 8);
    idle(1);
    cyc(0, 0, 1, 0, 0);
    idle(1);

    // Scenario 3: auto-repeat in SEL_MM
    seen_up = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0, 1, 0);
      if (i == 0) chk("s3_first", enUP, 1);
    end
    idle(6);
    chk("s3_pulses", seen_up, 5);

    // Scenario 4: both held, then up in IDLE
    seen_up = 0;
    seen_dn = 0;
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 1);
    idle(2);
    cyc(1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    idle(2);
    chk("s4_pulses", seen_up + seen_dn, 0);

    // Scenario 5: timeout from SEL_HH, held button blocks it
    cyc(1, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 1, 0, 0);
    idle(19);
    chk("s5_before", en_count, 10);
    idle(1);
    chk("s5_timeout", en_count, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 0);
    chk("s5_held", en_count, 9);
    idle(2);

    // Scenario 6: reset during down auto-repeat
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("s6_rst_cnt", en_count, 0);
    chk("s6_rst_dn", enDOWN, 0);
    seen_dn = 0;
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
    chk("s6_nopulse", seen_dn, 0);
    idle(2);
    cyc(0, 0, 0, 0, 1);
    chk("s6_repress", enDOWN, 1);
    idle(2);

    // Random activity against the model
    for (int k = 0; k < 5; k++) lv[k] = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 39) == 0) lv[0] = !lv[0];
      if ($urandom_range(0, 11) == 0) lv[1] = !lv[1];
      if ($urandom_range(0, 11) == 0) lv[2] = !lv[2];
      if ($urandom_range(0, 9) == 0) lv[3] = !lv[3];
      if ($urandom_range(0, 9) == 0) lv[4] = !lv[4];
      b = $urandom_range(0, 299);
      cyc(lv[0], lv[1], lv[2], lv[3], lv[4], b != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/ctrl_edit_timer.md
CTRL_EDIT_TIMER -- requirements
Module: ctrl_edit_timer

Interface
REQ-001 The module SHALL have parameter REPEAT_DLY, default 50_000_000, meaning hold cycles before auto-repeat starts.
REQ-002 The module SHALL have parameter REPEAT_PER, default 10_000_000, meaning cycles between auto-repeat pulses.
REQ-003 The module SHALL have parameter TIMEOUT, default 500_000_000, meaning idle cycles before edit mode is abandoned.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port btn_edit, input, 1 bit: edit-mode toggle; debounced and synchronized upstream.
REQ-007 The module SHALL have port btn_left, input, 1 bit: field selection toward seconds.
REQ-008 The module SHALL have port btn_right, input, 1 bit: field selection toward hours.
REQ-009 The module SHALL have ports btn_up and btn_down, inputs, 1 bit each: increment and decrement request levels.
REQ-010 The module SHALL have port en_count, output, 4 bits: field code driven to the timer counters.
REQ-011 The module SHALL have ports enUP and enDOWN, outputs, 1 bit each: single-cycle step pulses.
REQ-012 The module SHALL have port edit_active, output, 1 bit: high in any field-selected state.

Function
REQ-013 Field codes SHALL be: 0 = none; 8 = seconds (SS_T); 9 = minutes (MM_T); 10 = hours (HH_T).
REQ-014 The FSM SHALL use states IDLE, SEL_SS, SEL_MM, SEL_HH; en_count SHALL be a registered decode of the state (0/8/9/10).
REQ-015 Every button SHALL be edge-detected by comparing it with its value registered on the previous cycle.
REQ-016 In IDLE, a rising edge on btn_edit SHALL move the FSM to SEL_MM.
REQ-017 In any SEL_* state, a rising edge on btn_edit SHALL move the FSM to IDLE.
REQ-018 A btn_right rising edge SHALL step SEL_SS->SEL_MM->SEL_HH->SEL_SS.
REQ-019 A btn_left rising edge SHALL step in the reverse order of REQ-018.
REQ-020 If btn_edit and a left/right edge occur in the same cycle, btn_edit SHALL win; simultaneous left and right edges SHALL be ignored.
REQ-021 In a SEL_* state, a btn_up rising edge SHALL produce enUP=1 on the next cycle, for exactly one cycle.
REQ-022 The btn_down rising edge SHALL behave the same way, producing enDOWN.
REQ-023 btn_up and btn_down high together SHALL produce no pulses and SHALL clear the hold counter.
REQ-024 Auto-repeat: while exactly one of btn_up/btn_down stays high, after REPEAT_DLY cycles from its edge a pulse SHALL issue, then one pulse every REPEAT_PER cycles until release.
REQ-025 enUP and enDOWN SHALL never be high together, and SHALL never be high in IDLE.
REQ-026 A field change SHALL clear the hold counter; no pulse SHALL issue in the cycle en_count changes.
REQ-027 Timeout counter: reset on any button edge or while any button is held; when it reaches TIMEOUT-1 in a SEL_* state, the FSM SHALL return to IDLE on the next cycle.
REQ-028 Counters SHALL saturate rather than wrap; widths SHALL be $clog2(max parameter + 1).
REQ-029 Wrap-around of the counted value (59->0, 0->59) SHALL remain the counter's responsibility; this block only issues pulses.

Reset
REQ-030 With reset=0 at a clk edge, the following SHALL apply: state=IDLE, en_count=0, enUP=0, enDOWN=0, edit_active=0, all counters=0, and edge registers loaded with current button levels (no spurious edge after release).
REQ-031 Reset mid-hold SHALL cancel auto-repeat; a button still held after reset SHALL not pulse until released and pressed again.

Structure
REQ-032 Field codes, state encoding, and default timing constants SHALL live in shared package timer_ctrl_pkg, reused by the MM_T/HH_T/SS_T counters.
REQ-033 One sub-module SHALL exist: btn_repeat, which covers edge detection plus the hold/repeat counter. It SHALL be instantiated twice (up, down).

Verification (REPEAT_DLY=5, REPEAT_PER=3, TIMEOUT=20)
REQ-034 Scenario 1: reset, then btn_edit pulse -> en_count=9 and edit_active=1 one cycle later; second pulse -> en_count=0.
REQ-035 Scenario 2: in SEL_MM, btn_right three edges -> en_count 10, 8, 9; btn_left once -> 8.
REQ-036 Scenario 3: in SEL_MM, hold btn_up 15 cycles -> enUP pulses at cycles 1, 6, 9, 12, 15 after the edge, then none after release.
REQ-037 Scenario 4: btn_up and btn_down both high 10 cycles -> no pulses; in IDLE, btn_up edge -> no pulse.
REQ-038 Scenario 5: enter SEL_HH, no buttons for 20 cycles -> IDLE with en_count=0; a held button prevents the timeout.
REQ-039 Scenario 6: reset asserted during auto-repeat with btn_down held -> all outputs 0; no enDOWN until release and re-press.
